// File: rtl/load_store_unit_pkg.sv
// Shared constants for the RV32I data-memory path: funct3 load/store encodings,
// addressable-unit modes and the request legality rule.
package load_store_unit_pkg;

  localparam int LSU_ADDR_WIDTH = 32;
  localparam int LSU_WORD_WIDTH = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [1:0] BYTE_MEMORY_MODE = 2'b00;
  localparam logic [1:0] HALF_MEMORY_MODE = 2'b01;
  localparam logic [1:0] WORD_MEMORY_MODE = 2'b10;

  // A request is rejected for an unsupported funct3 or a size-misaligned address.
  function automatic logic reqIllegal(input logic isWrite, input logic [2:0] funct3,
                                      input logic [1:0] addrLow);
    logic legalF3;
    logic misaligned;
    if (isWrite) begin
      legalF3 = (funct3 == F3_SB) || (funct3 == F3_SH) || (funct3 == F3_SW);
    end else begin
      legalF3 = (funct3 == F3_LB) || (funct3 == F3_LH) || (funct3 == F3_LW) ||
                (funct3 == F3_LBU) || (funct3 == F3_LHU);
    end
    case (funct3[1:0])
      HALF_MEMORY_MODE: misaligned = addrLow[0];
      WORD_MEMORY_MODE: misaligned = (addrLow != 2'b00);
      default:          misaligned = 1'b0;
    endcase
    return ~legalF3 | misaligned;
  endfunction

endpackage

// File: rtl/load_store_unit_extender.sv
// Sign/zero extension of a right-justified memory word according to the load funct3;
// shared with the writeback path.
module load_extender
  import load_store_unit_pkg::*;
#(
  parameter int WORD_WIDTH = LSU_WORD_WIDTH
) (
  input  logic [2:0]            funct3_i,
  input  logic [WORD_WIDTH-1:0] rawWord_i,
  output logic [WORD_WIDTH-1:0] extWord_o
);

  always_comb begin
    extWord_o = '0;
    case (funct3_i)
      F3_LB:   extWord_o = {{(WORD_WIDTH-8){rawWord_i[7]}}, rawWord_i[7:0]};
      F3_LBU:  extWord_o = {{(WORD_WIDTH-8){1'b0}}, rawWord_i[7:0]};
      F3_LH:   extWord_o = {{(WORD_WIDTH-16){rawWord_i[15]}}, rawWord_i[15:0]};
      F3_LHU:  extWord_o = {{(WORD_WIDTH-16){1'b0}}, rawWord_i[15:0]};
      F3_LW:   extWord_o = rawWord_i;
      default: extWord_o = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Initiator side of the byte-addressed data-memory interface: one load/store at a
// time, single-cycle memory strobe, one-cycle response pulse.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = LSU_ADDR_WIDTH,
  parameter int WORD_WIDTH = LSU_WORD_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  reqValid,
  output logic                  reqReady,
  input  logic                  reqWrite,
  input  logic [2:0]            reqFunct3,
  input  logic [ADDR_WIDTH-1:0] reqAddr,
  input  logic [WORD_WIDTH-1:0] reqData,
  output logic                  rspValid,
  output logic [WORD_WIDTH-1:0] rspData,
  output logic                  rspError,
  output logic                  memRead,
  output logic                  memWrite,
  output logic [1:0]            addrUnit,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [WORD_WIDTH-1:0] memDataOut,
  input  logic [WORD_WIDTH-1:0] memDataIn
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e                state_q, state_d;
  logic [2:0]            funct3_q, funct3_d;
  logic                  write_q, write_d;
  logic [1:0]            addrUnit_q, addrUnit_d;
  logic [ADDR_WIDTH-1:0] address_q, address_d;
  logic [WORD_WIDTH-1:0] memDataOut_q, memDataOut_d;
  logic                  memRead_q, memRead_d;
  logic                  memWrite_q, memWrite_d;
  logic [WORD_WIDTH-1:0] rspData_q, rspData_d;
  logic                  rspError_q, rspError_d;
  logic [WORD_WIDTH-1:0] extWord;

  load_extender #(.WORD_WIDTH(WORD_WIDTH)) uExtender (
    .funct3_i  (funct3_q),
    .rawWord_i (memDataIn),
    .extWord_o (extWord)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      funct3_q     <= '0;
      write_q      <= 1'b0;
      addrUnit_q   <= BYTE_MEMORY_MODE;
      address_q    <= '0;
      memDataOut_q <= '0;
      memRead_q    <= 1'b0;
      memWrite_q   <= 1'b0;
      rspData_q    <= '0;
      rspError_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      funct3_q     <= funct3_d;
      write_q      <= write_d;
      addrUnit_q   <= addrUnit_d;
      address_q    <= address_d;
      memDataOut_q <= memDataOut_d;
      memRead_q    <= memRead_d;
      memWrite_q   <= memWrite_d;
      rspData_q    <= rspData_d;
      rspError_q   <= rspError_d;
    end
  end

  // Memory strobes are set on the transition into ISSUE so they are high for that cycle only.
  always_comb begin
    state_d      = state_q;
    funct3_d     = funct3_q;
    write_d      = write_q;
    addrUnit_d   = addrUnit_q;
    address_d    = address_q;
    memDataOut_d = memDataOut_q;
    memRead_d    = 1'b0;
    memWrite_d   = 1'b0;
    rspData_d    = rspData_q;
    rspError_d   = rspError_q;
    case (state_q)
      IDLE: begin
        if (reqValid) begin
          funct3_d     = reqFunct3;
          write_d      = reqWrite;
          addrUnit_d   = reqFunct3[1:0];
          address_d    = reqAddr;
          memDataOut_d = reqData;
          if (reqIllegal(reqWrite, reqFunct3, reqAddr[1:0])) begin
            state_d    = RESP;
            rspError_d = 1'b1;
            rspData_d  = '0;
          end else begin
            state_d    = ISSUE;
            memRead_d  = ~reqWrite;
            memWrite_d = reqWrite;
          end
        end
      end
      ISSUE: begin
        if (write_q) begin
          state_d    = RESP;
          rspError_d = 1'b0;
          rspData_d  = '0;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        state_d    = RESP;
        rspError_d = 1'b0;
        rspData_d  = extWord;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign reqReady   = (state_q == IDLE) & ~rst;
  assign rspValid   = (state_q == RESP);
  assign rspData    = rspData_q;
  assign rspError   = rspError_q;
  assign memRead    = memRead_q;
  assign memWrite   = memWrite_q;
  assign addrUnit   = addrUnit_q;
  assign address    = address_q;
  assign memDataOut = memDataOut_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench: byte-array memory model behind the DUT plus a golden byte
// array and per-request expectations derived from the RV32I load/store rules.
module tb_load_store_unit;

  localparam int AW = 32;
  localparam int WW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          reqValid;
  logic          reqReady;
  logic          reqWrite;
  logic [2:0]    reqFunct3;
  logic [AW-1:0] reqAddr;
  logic [WW-1:0] reqData;
  logic          rspValid;
  logic [WW-1:0] rspData;
  logic          rspError;
  logic          memRead;
  logic          memWrite;
  logic [1:0]    addrUnit;
  logic [AW-1:0] address;
  logic [WW-1:0] memDataOut;
  logic [WW-1:0] memDataIn = '0;

  int checks = 0;
  int errors = 0;

  logic [7:0] simMem [0:255];
  logic [7:0] refMem [0:255];

  load_store_unit #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW)) dut (
    .clk        (clk),
    .rst        (rst),
    .reqValid   (reqValid),
    .reqReady   (reqReady),
    .reqWrite   (reqWrite),
    .reqFunct3  (reqFunct3),
    .reqAddr    (reqAddr),
    .reqData    (reqData),
    .rspValid   (rspValid),
    .rspData    (rspData),
    .rspError   (rspError),
    .memRead    (memRead),
    .memWrite   (memWrite),
    .addrUnit   (addrUnit),
    .address    (address),
    .memDataOut (memDataOut),
    .memDataIn  (memDataIn)
  );

  always #5 clk = ~clk;

  // Synchronous byte-addressed memory returning the selected unit right-justified.
  always @(posedge clk) begin : memModel
    logic [7:0] a;
    a = address[7:0];
    if (memWrite) begin
      simMem[a] <= memDataOut[7:0];
      if (addrUnit != 2'b00) simMem[a + 8'd1] <= memDataOut[15:8];
      if (addrUnit == 2'b10) begin
        simMem[a + 8'd2] <= memDataOut[23:16];
        simMem[a + 8'd3] <= memDataOut[31:24];
      end
    end
    if (memRead) begin
      case (addrUnit)
        2'b00:   memDataIn <= {24'h0, simMem[a]};
        2'b01:   memDataIn <= {16'h0, simMem[a + 8'd1], simMem[a]};
        default: memDataIn <= {simMem[a + 8'd3], simMem[a + 8'd2], simMem[a + 8'd1], simMem[a]};
      endcase
    end
  end

  always @(negedge clk) begin
    checks++;
    if (memRead && memWrite) begin
      errors++;
      $display("[TB] FAIL memExclusive: memRead=%0b memWrite=%0b, required not both 1 at %0t",
               memRead, memWrite, $time);
    end
  end

  function automatic int accessSize(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic bit modelError(input bit w, input logic [2:0] f3, input int addr);
    bit legal;
    if (w) legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
    else   legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    return !legal || ((addr % accessSize(f3)) != 0);
  endfunction

  function automatic logic [31:0] modelLoad(input logic [2:0] f3, input int addr);
    logic [31:0] val;
    int size;
    size = accessSize(f3);
    val = '0;
    for (int i = 0; i < size; i++) val = val | (32'(refMem[(addr + i) % 256]) << (8 * i));
    if (!f3[2] && size < 4 && val[8 * size - 1]) val = val | (32'hFFFF_FFFF << (8 * size));
    return val;
  endfunction

  task automatic modelStore(input logic [2:0] f3, input int addr, input logic [31:0] data);
    for (int i = 0; i < accessSize(f3); i++) refMem[(addr + i) % 256] = data[8 * i +: 8];
  endtask

  // Presents one request (called at a negedge) and checks timing, strobes and response.
  task automatic doRequest(input bit w, input logic [2:0] f3, input int addr,
                           input logic [31:0] data, input bit hold, input string name,
                           output logic [31:0] gotData);
    bit          expErr;
    logic [31:0] expData;
    int          expLat, lat, guard, rdCount, wrCount, accCycle;
    bit          seen, badAddr;
    expErr  = modelError(w, f3, addr);
    expLat  = expErr ? 1 : (w ? 2 : 3);
    expData = (expErr || w) ? 32'h0 : modelLoad(f3, addr);
    if (w && !expErr) modelStore(f3, addr, data);
    gotData   = 'x;
    reqValid  = 1'b1;
    reqWrite  = w;
    reqFunct3 = f3;
    reqAddr   = AW'(addr);
    reqData   = data;
    guard = 0;
    while (!reqReady && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (!reqReady) begin
      errors++;
      $display("[TB] FAIL %s readyTimeout: reqReady=%0b, required 1", name, reqReady);
      reqValid = 1'b0;
      return;
    end
    lat = 0; seen = 0; rdCount = 0; wrCount = 0; accCycle = 0; badAddr = 0;
    while (!seen && lat < 8) begin
      @(negedge clk);
      lat++;
      if (!hold) reqValid = 1'b0;
      if (memRead || memWrite) begin
        if (memRead) rdCount++;
        if (memWrite) wrCount++;
        accCycle = lat;
        if (address !== AW'(addr) || addrUnit !== f3[1:0] || (memWrite && memDataOut !== data))
          badAddr = 1;
      end
      if (rspValid) begin
        seen = 1;
        gotData = rspData;
      end else begin
        checks++;
        if (reqReady !== 1'b0) begin
          errors++;
          $display("[TB] FAIL %s busyReady: reqReady=%0b in cycle N+%0d, required 0", name, reqReady, lat);
        end
      end
    end
    checks++;
    if (!seen || lat != expLat) begin
      errors++;
      $display("[TB] FAIL %s latency: rspValid seen=%0b at N+%0d, required N+%0d", name, seen, lat, expLat);
    end
    checks++;
    if (rspError !== expErr) begin
      errors++;
      $display("[TB] FAIL %s rspError: got %0b, required %0b", name, rspError, expErr);
    end
    checks++;
    if (rspData !== expData) begin
      errors++;
      $display("[TB] FAIL %s rspData: got %08h, required %08h", name, rspData, expData);
    end
    checks++;
    if (rdCount != ((!w && !expErr) ? 1 : 0) || wrCount != ((w && !expErr) ? 1 : 0) ||
        (!expErr && accCycle != 1)) begin
      errors++;
      $display("[TB] FAIL %s strobes: reads=%0d writes=%0d at N+%0d, required reads=%0d writes=%0d at N+1",
               name, rdCount, wrCount, accCycle, (!w && !expErr) ? 1 : 0, (w && !expErr) ? 1 : 0);
    end
    checks++;
    if (badAddr) begin
      errors++;
      $display("[TB] FAIL %s accessFields: address=%08h addrUnit=%0b data=%08h, required %08h %0b %08h",
               name, address, addrUnit, memDataOut, addr, f3[1:0], data);
    end
    if (!hold) begin
      @(negedge clk);
      checks++;
      if (rspValid !== 1'b0 || rspData !== expData || reqReady !== 1'b1) begin
        errors++;
        $display("[TB] FAIL %s afterResp: rspValid=%0b rspData=%08h reqReady=%0b, required 0 %08h 1",
                 name, rspValid, rspData, reqReady, expData);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    reqValid = 1'b0; reqWrite = 1'b0; reqFunct3 = '0; reqAddr = '0; reqData = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (reqReady !== 1'b0 || rspValid !== 1'b0 || rspError !== 1'b0 || rspData !== '0) begin
      errors++;
      $display("[TB] FAIL resetRsp: ready=%0b valid=%0b err=%0b data=%08h, required all 0",
               reqReady, rspValid, rspError, rspData);
    end
    checks++;
    if (memRead !== 1'b0 || memWrite !== 1'b0 || addrUnit !== 2'b00 || address !== '0 || memDataOut !== '0) begin
      errors++;
      $display("[TB] FAIL resetMem: rd=%0b wr=%0b unit=%0b addr=%08h dout=%08h, required all 0",
               memRead, memWrite, addrUnit, address, memDataOut);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (reqReady !== 1'b1) begin
      errors++;
      $display("[TB] FAIL resetRelease: reqReady=%0b, required 1", reqReady);
    end
  endtask

  task automatic test_loads();
    logic [31:0] got;
    logic [31:0] req [5];
    logic [2:0]  f3s [5];
    f3s = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
    req = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_FF80, 32'h0000_FF80, 32'h1234_FF80};
    for (int i = 0; i < 5; i++) begin
      doRequest(1'b0, f3s[i], 32'h10, 32'h0, 1'b0, "preloadLoad", got);
      checks++;
      if (got !== req[i]) begin
        errors++;
        $display("[TB] FAIL preloadLoad%0d: got %08h, required %08h", i, got, req[i]);
      end
    end
  endtask

  task automatic test_store();
    logic [31:0] got;
    doRequest(1'b1, 3'b010, 32'h20, 32'hDEAD_BEEF, 1'b0, "storeWord", got);
    doRequest(1'b0, 3'b000, 32'h23, 32'h0, 1'b0, "loadAfterSw", got);
    checks++;
    if (got !== 32'hFFFF_FFDE) begin
      errors++;
      $display("[TB] FAIL lbAfterSw: got %08h, required ffffffde", got);
    end
    doRequest(1'b1, 3'b001, 32'h24, 32'hFFFF_ABCD, 1'b0, "storeHalf", got);
    doRequest(1'b0, 3'b101, 32'h24, 32'h0, 1'b0, "loadAfterSh", got);
    checks++;
    if (got !== 32'h0000_ABCD) begin
      errors++;
      $display("[TB] FAIL lhuAfterSh: got %08h, required 0000abcd", got);
    end
    doRequest(1'b0, 3'b100, 32'h26, 32'h0, 1'b0, "untouchedByte", got);
  endtask

  task automatic test_errors();
    logic [31:0] got;
    doRequest(1'b0, 3'b010, 32'h22, 32'h0, 1'b0, "misalignedLw", got);
    doRequest(1'b0, 3'b001, 32'h11, 32'h0, 1'b0, "misalignedLh", got);
    doRequest(1'b0, 3'b011, 32'h30, 32'h0, 1'b0, "illegalLoadF3", got);
    doRequest(1'b1, 3'b100, 32'h30, 32'h5555_5555, 1'b0, "illegalStoreF3", got);
    doRequest(1'b1, 3'b001, 32'h33, 32'h1234_5678, 1'b0, "misalignedSh", got);
  endtask

  task automatic test_back_to_back();
    logic [31:0] got;
    doRequest(1'b0, 3'b010, 32'h10, 32'h0, 1'b1, "b2bLoad", got);
    doRequest(1'b1, 3'b000, 32'h40, 32'h0000_00A5, 1'b1, "b2bStore", got);
    doRequest(1'b0, 3'b000, 32'h40, 32'h0, 1'b1, "b2bLoadBack", got);
    reqValid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    reqValid = 1'b1; reqWrite = 1'b0; reqFunct3 = 3'b010; reqAddr = 32'h10; reqData = '0;
    @(negedge clk);
    reqValid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (rspValid !== 1'b0 || rspData !== '0 || rspError !== 1'b0 || reqReady !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midResetRsp: valid=%0b data=%08h err=%0b ready=%0b, required all 0",
               rspValid, rspData, rspError, reqReady);
    end
    checks++;
    if (memRead !== 1'b0 || memWrite !== 1'b0 || addrUnit !== 2'b00 || address !== '0 || memDataOut !== '0) begin
      errors++;
      $display("[TB] FAIL midResetMem: rd=%0b wr=%0b unit=%0b addr=%08h dout=%08h, required all 0",
               memRead, memWrite, addrUnit, address, memDataOut);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (reqReady !== 1'b1 || rspValid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midResetRelease: ready=%0b valid=%0b, required 1 0", reqReady, rspValid);
    end
  endtask

  task automatic test_random();
    logic [31:0] got;
    for (int i = 0; i < 60; i++) begin
      doRequest(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), int'($urandom_range(0, 252)),
                $urandom, 1'b0, "random", got);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      simMem[i] = 8'($urandom);
      refMem[i] = simMem[i];
    end
    simMem[8'h10] = 8'h80; simMem[8'h11] = 8'hFF; simMem[8'h12] = 8'h34; simMem[8'h13] = 8'h12;
    refMem[8'h10] = 8'h80; refMem[8'h11] = 8'hFF; refMem[8'h12] = 8'h34; refMem[8'h13] = 8'h12;
    test_reset();
    test_loads();
    test_store();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator side of the byte-addressed data-memory interface in the RV32I core. Accepts one load or store request at a time from the execute/memory stage, drives the synchronous memory's read/write controls, addressable-unit select, address and write data, then returns a sign- or zero-extended load result, or a store completion, as a one-cycle response. Misaligned and illegal-width requests are rejected without touching memory.

## Interface
- ADDR_WIDTH, `ADDR_WIDTH, byte-address width shared with the memory
- WORD_WIDTH, `WORD_WIDTH, data width (32)
- clk  in  1  clock, all state updates on posedge
- rst  in  1  synchronous, active-high reset
- reqValid  in  1  core presents a request
- reqReady  out  1  unit can accept; a request transfers on reqValid & reqReady
- reqWrite  in  1  1 = store, 0 = load
- reqFunct3  in  3  RV32I load/store funct3
- reqAddr  in  ADDR_WIDTH  byte address
- reqData  in  WORD_WIDTH  store data, low bits used
- rspValid  out  1  one-cycle completion pulse
- rspData  out  WORD_WIDTH  extended load data; 0 for stores and errors
- rspError  out  1  valid with rspValid; misaligned or illegal funct3
- memRead, memWrite  out  1  memory controls, never both high
- addrUnit  out  2  00 byte, 01 halfword, 10 word
- address  out  ADDR_WIDTH  memory byte address
- memDataOut  out  WORD_WIDTH  to memory dataIn
- memDataIn  in  WORD_WIDTH  from memory dataOut, valid the cycle after memRead

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. reqReady = (state == IDLE) & ~rst.
- IDLE, on accept: register funct3 and reqWrite. Load addrUnit <= funct3[1:0], address <= reqAddr, memDataOut <= reqData (unshifted).
- Error check at accept: loads are legal for funct3 000, 001, 010, 100, 101; stores for 000, 001, 010. A halfword access is misaligned when addr[0] = 1; a word access when addr[1:0] != 0. On an error, go to RESP with rspError = 1 and rspData = 0. No memory access occurs.
- Otherwise go to ISSUE. memRead or memWrite is a registered output, high for exactly the ISSUE cycle.
- ISSUE: a store goes to RESP; a load goes to WAIT.
- WAIT: memDataIn holds memory data. Capture the extended value into rspData, then go to RESP.
  - LB: sign-extend [7:0]. LBU: zero-extend [7:0].
  - LH: sign-extend [15:0]. LHU: zero-extend [15:0].
  - LW: pass through.
- RESP: rspValid = 1 for one cycle, then IDLE. The response has no backpressure; the core always accepts it.
- address, addrUnit and memDataOut hold their values until the next accept.
- rspData and rspError hold their values until the next RESP.

## Timing
- Request accepted in cycle N:
  - Load: memRead high in N+1, data sampled in N+2, rspValid in N+3.
  - Store: memWrite high in N+1, rspValid in N+2.
  - Error: rspValid and rspError in N+1.
- reqReady returns in the cycle after RESP. Throughput is one request per 2 cycles (error), 3 (store) or 4 (load).
- Reset values: state IDLE, reqReady 0 while rst is high, and every other output 0 (addrUnit = byte mode).
- Reset mid-operation aborts to IDLE with no rspValid. If memWrite is already high in the cycle rst rises, that write still lands, because memory has no reset. No further access is issued.
- reqValid during RESP, WAIT or ISSUE is ignored; the core holds it until reqReady.

## Structure
- rv32i_defs.sv holds the existing *_MEMORY_MODE defines. Add the funct3 load/store encodings there.
- The FSM state enum is local to the module.
- One combinational sub-module, load_extender (funct3 and raw word in, extended word out), reused by the future writeback path.

## Test plan
- Memory bytes 0x10..0x13 preloaded as 80 FF 34 12:
  - LB 0x10 -> rspData 0xFFFFFF80 in N+3.
  - LBU 0x10 -> 0x00000080.
  - LH 0x10 -> 0xFFFFFF80.
  - LHU 0x10 -> 0x0000FF80.
  - LW 0x10 -> 0x1234FF80.
- SW 0x20 with data 0xDEADBEEF -> memWrite high only in N+1 with addrUnit = 10 and rspValid in N+2. A following LB 0x23 returns 0xFFFFFFDE.
- SH 0x24 with data 0xFFFFABCD, then LHU 0x24 -> 0x0000ABCD. LBU 0x26 is unchanged from its preload.
- LW 0x22, LH 0x11 and load funct3 011 -> rspError = 1 and rspData = 0 in N+1. memRead and memWrite stay low throughout.
- reqValid held high over three back-to-back requests -> each is accepted only when reqReady = 1. Assert every cycle that memRead & memWrite is never 1.
- rst pulsed during WAIT of an LW -> no rspValid, all outputs 0 next cycle, reqReady = 1 in the first cycle after rst falls.
